dmem_stream_reader: RTL and testbench

Read-side consumer of the data memory's read-only port 1 (addr1/rd1). On a start command it walks a word-aligned region of the data memory and serialises each 32-bit word into a little-endian byte stream with a valid/ready handshake. The byte stream feeds a downstream byte sink (UART transmitter or debug dump). It never writes memory and never touches port 0, so it runs concurrently with the processor.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_stream_reader_word_serializer.sv | 74 +++++++
 rtl/dmem_stream_reader.sv | 125 ++++++++++++
 tb/tb_dmem_stream_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stream reader: memory geometry,
// bus widths and the reader FSM state encoding.
package dmem_pkg;

    localparam int DMEM_DEPTH_WORDS = 1024;
    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int BYTE_W           = 8;
    localparam int BYTE_IDX_W       = $clog2(DATA_W / BYTE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/dmem_stream_reader_word_serializer.sv
// Holds one fetched 32-bit word and presents it as four little-endian bytes
// on a valid/ready stream; flags the cycle in which byte 3 is accepted.
module word_serializer
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              load_last_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_byte_o,
    output logic              out_last_o,
    output logic              word_done_o
);

    logic [DATA_W-1:0]     buf_q,       buf_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q,  byte_idx_d;
    logic                  valid_q,     valid_d;
    logic                  last_word_q, last_word_d;
    logic                  last_q,      last_d;
    logic                  accept;

    assign accept = valid_q && out_ready_i;

    // The buffer shifts right on every accepted byte, so the current byte is
    // always the low lane and out_byte comes straight from a flop.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can leave it unassigned (no latch).
        buf_d       = buf_q;
        byte_idx_d  = byte_idx_q;
        valid_d     = valid_q;
        last_word_d = last_word_q;
        last_d      = last_q;
        if (load_i) begin
            buf_d       = load_data_i;
            byte_idx_d  = '0;
            valid_d     = 1'b1;
            last_word_d = load_last_i;
            last_d      = 1'b0;
        end else if (accept) begin
            buf_d      = {{BYTE_W{1'b0}}, buf_q[DATA_W-1:BYTE_W]};
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
            last_d     = last_word_q && (byte_idx_q == BYTE_IDX_W'(2));
            if (byte_idx_q == '1) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            buf_q       <= '0;
            byte_idx_q  <= '0;
            valid_q     <= 1'b0;
            last_word_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            byte_idx_q  <= byte_idx_d;
            valid_q     <= valid_d;
            last_word_q <= last_word_d;
            last_q      <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_byte_o  = buf_q[BYTE_W-1:0];
    assign out_last_o  = last_q;
    assign word_done_o = accept && (byte_idx_q == '1);

endmodule

// File: rtl/dmem_stream_reader.sv
// Walks a word-aligned region of data memory through read port 1 and streams
// it out as little-endian bytes; runs alongside the CPU without writing memory.
module dmem_stream_reader
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int LEN_W       = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last
);

    localparam int                WIDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(DEPTH_WORDS);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(DEPTH_WORDS - 1);

    rd_state_e         state_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDX_W-1:0] idx_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [WIDX_W-1:0] base_idx;
    logic [WIDX_W-1:0] idx_d;
    logic [LEN_W-1:0]  len_d;
    logic              last_word;
    logic              word_done;
    logic              unused_addr_bits;

    assign base_idx         = base_addr[WIDX_W+1:2];
    assign unused_addr_bits = ^{base_addr[ADDR_W-1:WIDX_W+2], base_addr[1:0]};

    always_comb begin
        idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + WIDX_W'(1);
        len_d     = (len_words > MAX_LEN) ? MAX_LEN : len_words;
        last_word = (count_q == len_q - LEN_W'(1));
    end

    // mem_addr is registered on entry to FETCH and otherwise holds, so the
    // memory sees a stable address for the whole FETCH cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            count_q    <= '0;
            len_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q   <= base_idx;
                        len_q   <= len_d;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            mem_addr_q <= ADDR_W'({base_idx, 2'b00});
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (word_done) begin
                        if (last_word) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            count_q    <= count_q + LEN_W'(1);
                            idx_q      <= idx_d;
                            mem_addr_q <= ADDR_W'({idx_d, 2'b00});
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    word_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (state_q == ST_FETCH),
        .load_last_i (last_word),
        .load_data_i (mem_rdata),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_byte_o  (out_byte),
        .out_last_o  (out_last),
        .word_done_o (word_done)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Directed bench for dmem_stream_reader: a behavioural memory on port 1 and a
// scoreboard of expected bytes and FETCH addresses, checked as the DUT emits them.
module tb_dmem_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] len_words;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    logic [31:0] mem [0:1023];
    logic [8:0]  exp_bytes [$];
    logic [31:0] exp_addrs [$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    dmem_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one transfer, built from the bench's own memory image.
    task automatic push_xfer(input logic [31:0] b, input int l);
        logic [31:0] data;
        for (int w = 0; w < l; w++) begin
            int idx;
            idx  = (int'(b[11:2]) + w) % 1024;
            data = mem[idx];
            exp_addrs.push_back(32'(idx) << 2);
            for (int j = 0; j < 4; j++) begin
                exp_bytes.push_back({(w == l - 1) && (j == 3), data[8*j +: 8]});
            end
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [10:0] l);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len_words = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 32'hFFFF_FFFF;
        len_words = 11'h7FF;
    endtask

    // Counts sample points (negedges) after the accepting edge until done.
    task automatic wait_done(input string tag, input int max_cyc, input int exp_n);
        int n;
        bit found;
        n     = 0;
        found = 1'b0;
        while (n < max_cyc && !found) begin
            @(negedge clk);
            n++;
            if (done) found = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_latency"}, 32'(n), 32'(exp_n));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            check({tag, "_valid_at_done"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        end
        check({tag, "_bytes_drained"}, 32'(exp_bytes.size()), 32'd0);
        check({tag, "_fetches_drained"}, 32'(exp_addrs.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_byte"},  32'(out_byte),  32'd0);
        check({tag, "_mem_addr"},  mem_addr,       32'd0);
    endtask

    // Scoreboard monitor: accepted bytes and FETCH-cycle addresses.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid && out_ready) begin
            check("byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
            if (exp_bytes.size() != 0) begin
                e = exp_bytes.pop_front();
                check("out_byte", 32'(out_byte), 32'(e[7:0]));
                check("out_last", 32'(out_last), 32'(e[8]));
            end
        end
        if (rst_n && busy && !out_valid && !done) begin
            check("fetch_expected", 32'(exp_addrs.size() != 0), 32'd1);
            if (exp_addrs.size() != 0) begin
                check("fetch_mem_addr", mem_addr, exp_addrs.pop_front());
            end
        end
    end

    initial begin
        bit hit;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len_words = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDDCCBBAA;
        mem[8]    = 32'h03020100;
        mem[9]    = 32'h07060504;
        mem[10]   = 32'h0B0A0908;
        mem[1023] = 32'h44332211;
        mem[0]    = 32'h88776655;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word, ready held high: AA BB CC DD, done six samples later.
        push_xfer(32'h10, 1);
        do_start(32'h10, 11'd1);
        wait_done("t1", 40, 6);

        // Three words: 15 cycles from first FETCH to done.
        push_xfer(32'h20, 3);
        do_start(32'h20, 11'd3);
        wait_done("t2", 60, 16);

        // Stall on BB for three cycles.
        push_xfer(32'h10, 1);
        do_start(32'h10, 11'd1);
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_byte",  32'(out_byte),  32'hBB);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_last",  32'(out_last),  32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t3", 40, 4);

        // Word index wraps from 1023 to 0.
        push_xfer(32'hFFC, 2);
        do_start(32'hFFC, 11'd2);
        wait_done("t4", 40, 11);

        // Zero length: done immediately, no bytes, no FETCH.
        do_start(32'h40, 11'd0);
        wait_done("t5_len0", 10, 1);

        // A start during a transfer is ignored.
        push_xfer(32'h10, 1);
        do_start(32'h10, 11'd1);
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 32'h20;
        len_words = 11'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5_ignore", 20, 3);
        repeat (4) @(negedge clk);
        check("t5_stays_idle", 32'(busy), 32'd0);

        // Reset while byte 2 (CC) is on the bus.
        push_xfer(32'h10, 1);
        do_start(32'h10, 11'd1);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (out_valid && out_byte == 8'hCC) hit = 1'b1;
        end
        check("t6_reached_cc", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_abort");
        @(negedge clk);
        check("t6_no_done", 32'(done), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_xfer(32'h10, 1);
        do_start(32'h10, 11'd1);
        wait_done("t6_restart", 40, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
